// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C bit-level sequencer.
//   cmd_t      - bus command encodings (START, STOP, WRITE, READ)
//   phase_t    - sequencer state: IDLE plus the four bit phases
//   CNT_W_DEF  - default width of the quarter-period counter
//   phase_oe() - open-drain enables {scl_oe, sda_oe} for a command/phase
//   next_phase() - phase successor (PH3 wraps to IDLE)
package i2c_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        PH0,
        PH1,
        PH2,
        PH3
    } phase_t;

    // Returns {scl_oe, sda_oe}; 1 pulls the line low.
    function automatic logic [1:0] phase_oe(cmd_t c, logic b, phase_t p);
        logic [1:0] oe;
        oe = 2'b00;
        case (c)
            CMD_START: begin
                case (p)
                    PH2:     oe = 2'b01;   // SDA falls while SCL high
                    PH3:     oe = 2'b11;
                    default: oe = 2'b00;
                endcase
            end
            CMD_STOP: begin
                case (p)
                    PH0:     oe = 2'b11;
                    PH1,
                    PH2:     oe = 2'b01;
                    default: oe = 2'b00;   // SDA rises while SCL high
                endcase
            end
            CMD_WRITE: begin
                case (p)
                    PH1,
                    PH2:     oe = {1'b0, ~b};
                    default: oe = {1'b1, ~b};
                endcase
            end
            default: begin             // READ: SDA released throughout
                case (p)
                    PH1,
                    PH2:     oe = 2'b00;
                    default: oe = 2'b10;
                endcase
            end
        endcase
        return oe;
    endfunction

    function automatic phase_t next_phase(phase_t p);
        case (p)
            PH0:     return PH1;
            PH1:     return PH2;
            PH2:     return PH3;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: loadable down-counter that times each bit phase.
//   clock_in, reset_n - clock, async active-low reset
//   load, load_val    - reload counter (takes priority over hold)
//   hold              - freeze the count this cycle
//   zero              - counter is 0 (last cycle of the phase)
// Stops at 0 rather than wrapping, so no CNT_W overflow is possible.
module i2c_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: bit-level I2C bus sequencer.
// One command (START/STOP/WRITE/READ) at a time over valid/ready; each is
// split into four phases of Q = max(qdiv,1) cycles and drives open-drain
// SCL/SDA enables.
//   clock_in, reset_n   - clock, async active-low reset
//   qdiv                - quarter-bit period, latched on accept
//   cmd_valid/cmd_ready - command handshake; cmd, cmd_bit = command, data bit
//   rsp_valid, rsp_bit  - 1-cycle completion pulse (WRITE/READ), sampled SDA
//   scl_oe, sda_oe      - 1 pulls the line low
//   scl_in, sda_in      - synchronized pad levels
//   busy                - not in IDLE
// Optional macro SCL_STRETCH_EN: the phase counter holds in PH1/PH2 while
// scl_in is low (slave clock stretching). Undefined: scl_in is unused.
module i2c_bit_ctrl
    import i2c_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] qdiv,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             cmd_bit,
    output logic             rsp_valid,
    output logic             rsp_bit,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             busy
);

    phase_t           state;
    phase_t           nxt;
    cmd_t             cmd_q;
    logic             bit_q;
    logic [CNT_W-1:0] q_m1;       // Q-1, reload value for later phases
    logic             zero;
    logic             hold;
    logic             accept;
    logic             advance;
    logic             is_rw;
    logic             load;
    logic [CNT_W-1:0] load_val;

`ifdef SCL_STRETCH_EN
    assign hold = (state == PH1 || state == PH2) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // A held cycle never ends a phase, so stretching adds exactly one cycle each.
    assign advance   = busy && zero && !hold;
    assign nxt       = next_phase(state);
    assign is_rw     = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);

    // qdiv==0 behaves as 1, i.e. reload value 0.
    assign load     = accept || (advance && state != PH3);
    assign load_val = accept ? ((qdiv == '0) ? '0 : qdiv - 1'b1) : q_m1;

    i2c_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .hold     (hold),
        .zero     (zero)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_q     <= CMD_START;
            bit_q     <= 1'b0;
            q_m1      <= '0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_bit   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                state            <= PH0;
                cmd_q            <= cmd_t'(cmd);
                bit_q            <= cmd_bit;
                q_m1             <= load_val;
                {scl_oe, sda_oe} <= phase_oe(cmd_t'(cmd), cmd_bit, PH0);
            end else if (advance) begin
                if (state == PH2 && is_rw)
                    rsp_bit <= sda_in;
                if (state == PH3) begin
                    // Enables stay at PH3 values: bus parked in IDLE.
                    state     <= IDLE;
                    rsp_valid <= is_rw;
                end else begin
                    state            <= nxt;
                    {scl_oe, sda_oe} <= phase_oe(cmd_q, bit_q, nxt);
                end
            end
        end
    end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
Bit-level I2C bus sequencer for the MPU6050 link.
- Takes one bus command at a time (START, STOP, WRITE bit, READ bit) over a valid/ready handshake.
- Splits each command into four equal phases timed by a programmable quarter-period counter, and drives open-drain SCL/SDA enables.
- Sits between the byte/transaction FSM above and the pad tristates below. It replaces the free-running fixed divider as the SCL timing source.

Parameters:
- CNT_W, 16, width of quarter-period counter and qdiv port.

Ports:
- clock_in  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- qdiv  in  CNT_W  quarter-bit period in clock_in cycles; 0 treated as 1; latched on command accept.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept; equals (state==IDLE).
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ.
- cmd_bit  in  1  data bit for WRITE; ignored otherwise.
- rsp_valid  out  1  one-cycle pulse, WRITE/READ completion only.
- rsp_bit  out  1  sda_in sampled in the bit (READ data or WRITE ack level).
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- scl_in  in  1  synchronized SCL pad level.
- sda_in  in  1  synchronized SDA pad level.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values (async, reset_n=0):
- state=IDLE, scl_oe=0, sda_oe=0, rsp_valid=0, rsp_bit=0, busy=0, counter=0.

States: IDLE, PH0, PH1, PH2, PH3.
- Accept when cmd_valid && cmd_ready in cycle T: latch cmd, cmd_bit, Q=max(qdiv,1). Enter PH0 at T+1.
- Each phase lasts exactly Q cycles; down-counter reloads Q-1 on each phase entry.
- On counter==0: PHn -> PHn+1. PH3 -> IDLE.
- rsp_valid asserts in the first IDLE cycle, i.e. T+1+4Q, for WRITE/READ only.
- cmd_ready is low during PH0–PH3, so there is a minimum one idle cycle between commands.
- cmd_valid while busy: ignored (not latched).

Phase output table (scl_oe, sda_oe), registered, applied from the first cycle of each phase:
- START: PH0 (0,0), PH1 (0,0), PH2 (0,1), PH3 (1,1).
- STOP: PH0 (1,1), PH1 (0,1), PH2 (0,1), PH3 (0,0).
- WRITE: PH0 (1,~b), PH1 (0,~b), PH2 (0,~b), PH3 (1,~b), where b = latched cmd_bit.
- READ: PH0 (1,0), PH1 (0,0), PH2 (0,0), PH3 (1,0).

Sampling and idle behaviour:
- rsp_bit captures sda_in on the last cycle of PH2, for WRITE and READ.
- In IDLE, scl_oe/sda_oe hold their PH3 values (bus parked).
- qdiv changes mid-command have no effect until the next accept.
- Reset mid-command returns to IDLE with both lines released. No rsp_valid is issued.
- Counter arithmetic is CNT_W bits, unsigned. Q=2^CNT_W−1 is legal and gives no wrap.

Optional Feature:
Macro SCL_STRETCH_EN.
- Defined: in PH1 and PH2 of any command, the phase counter holds (no decrement) while scl_in==0. This honours slave clock stretching. Phase length becomes Q plus the stretched cycles, and rsp_valid is delayed accordingly.
- Undefined: scl_in is unused and timing is strictly 4Q.

Decomposition:
Package i2c_pkg:
- command encodings (CMD_START, CMD_STOP, CMD_WRITE, CMD_READ).
- phase/state enum.
- CNT_W default constant.

Sub-module i2c_phase_timer:
- loadable down-counter with load, hold and zero-flag ports.
- Instantiated once.
- Subsumes the fixed clock-divider role.

Test Plan:
- Reset check: hold reset_n=0 mid-WRITE at PH1 -> scl_oe=0, sda_oe=0, busy=0 immediately (asynchronous). No rsp_valid after release.
- START then STOP, qdiv=2: START accepted at cycle 0 -> sda_oe rises at cycle 5, scl_oe rises at cycle 7, IDLE at cycle 9. STOP accepted at cycle 9 -> sda_oe=0 at cycle 16.
- WRITE, qdiv=3, cmd_bit=1, sda_in=0 (ack): accept at cycle 0 -> sda_oe=0 in cycles 1–12. scl_oe=1 in cycles 1–3, 0 in 4–9, 1 in 10–12. rsp_valid=1, rsp_bit=0 at cycle 13 only.
- READ, qdiv=0 (treated as 1), sda_in=1: phases of 1 cycle each -> rsp_valid at cycle 5, rsp_bit=1. sda_oe stays 0 throughout.
- Handshake: cmd_valid held high for a WRITE followed by a READ, qdiv=1 -> second accept at cycle 5 (first IDLE). The new cmd value presented at cycle 2 is not latched.
- Clock stretching, SCL_STRETCH_EN defined, qdiv=2, READ: scl_in forced 0 for 5 cycles during PH1 -> rsp_valid at cycle 14 instead of 9. With the macro undefined -> cycle 9.
